// File: rtl/ahfp_pkg.sv
// Shared definitions for the ahfp floating-point custom-instruction stages:
// result constants, operation encodings, FSM state encoding and
// IEEE-754 single-precision classification / clean-up helpers.
package ahfp_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    // Operation select encodings (custom-instruction n field)
    localparam logic [1:0] OP_AB   = 2'd0;   // A - B
    localparam logic [1:0] OP_BA   = 2'd1;   // B - A
    localparam logic [1:0] OP_ACC  = 2'd2;   // acc - A, acc <= result
    localparam logic [1:0] OP_LOAD = 2'd3;   // acc <= A, result = A

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == EXP_MAX) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == EXP_MAX) && (v[22:0] == 23'd0);
    endfunction

    // Assumes denormals have already been flushed, so exp=0 means zero.
    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:0] == 31'd0);
    endfunction

    // Denormals (exp=0) become zero of the same sign.
    function automatic logic [31:0] flush_denorm(input logic [31:0] v);
        return (v[30:23] == 8'd0) ? {v[31], 31'd0} : v;
    endfunction

    // Core results: any exp=FF is reported as signed infinity, any exp=00
    // (zero or denormal, either sign) as +0.
    function automatic logic [31:0] canon_result(input logic [31:0] v);
        if (v[30:23] == EXP_MAX) begin
            return {v[31], EXP_MAX, 23'd0};
        end else if (v[30:23] == 8'd0) begin
            return 32'd0;
        end
        return v;
    endfunction

endpackage

// File: rtl/ahfp_classify.sv
// Special-case screen for X - Y on flushed single-precision operands.
// Ports: x, y (effective minuend / subtrahend) in; bypass (result known
// without the core) and bypass_val (that result) out. Purely combinational.
module ahfp_classify
    import ahfp_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        bypass,
    output logic [31:0] bypass_val
);

    always_comb begin
        bypass     = 1'b1;
        bypass_val = 32'd0;
        if (is_nan(x) || is_nan(y)) begin
            bypass_val = QNAN;
        end else if (is_inf(x) && is_inf(y) && (x[31] == y[31])) begin
            bypass_val = QNAN;
        end else if (is_inf(x)) begin
            bypass_val = x;
        end else if (is_inf(y)) begin
            bypass_val = {~y[31], y[30:0]};
        end else if (x == y) begin
            bypass_val = 32'd0;
        end else if (is_zero(y)) begin
            bypass_val = x;
        end else if (is_zero(x)) begin
            bypass_val = {~y[31], y[30:0]};
        end else begin
            bypass = 1'b0;
        end
    end

endmodule

// File: rtl/ahfp_sub_ci.sv
// Multi-cycle custom-instruction front-end for the FP subtractor core.
// Ports: clk/reset/clk_en control; start/n/dataa/datab request; result/done
// response; core_dataa/core_datab/core_result connect the combinational core.
module ahfp_sub_ci
    import ahfp_pkg::*;
#(
    parameter int CORE_LAT = 2   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic [31:0] core_dataa,
    output logic [31:0] core_datab,
    input  logic [31:0] core_result
);

    localparam logic [3:0] CNT_INIT = 4'(CORE_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] acc;
    logic [31:0] a_f;
    logic [31:0] b_f;
    logic [31:0] acc_f;
    logic [31:0] x;
    logic [31:0] y;
    logic        bypass;
    logic [31:0] bypass_val;
    logic        take_fast;

    assign a_f   = flush_denorm(dataa);
    assign b_f   = flush_denorm(datab);
    assign acc_f = flush_denorm(acc);

    // Effective operands: result = X - Y
    always_comb begin
        x = a_f;
        y = b_f;
        case (n)
            OP_BA:   begin x = b_f;   y = a_f; end
            OP_ACC:  begin x = acc_f; y = a_f; end
            default: begin x = a_f;   y = b_f; end
        endcase
    end

    ahfp_classify u_classify (
        .x          (x),
        .y          (y),
        .bypass     (bypass),
        .bypass_val (bypass_val)
    );

    // Loads and special cases never touch the core.
    assign take_fast = (n == OP_LOAD) || bypass;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = take_fast ? ST_DONE : ST_EXEC;
            ST_EXEC: if (cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        done = (state == ST_DONE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            op_q       <= OP_AB;
            acc        <= 32'd0;
            result     <= 32'd0;
            core_dataa <= 32'd0;
            core_datab <= 32'd0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= n;
                        if (n == OP_LOAD) begin
                            result <= dataa;
                        end else if (bypass) begin
                            result <= bypass_val;
                        end else begin
                            core_dataa <= x;
                            core_datab <= y;
                            cnt        <= CNT_INIT;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == 4'd0) begin
                        result <= canon_result(core_result);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // result already holds this operation's answer
                    if ((op_q == OP_ACC) || (op_q == OP_LOAD)) begin
                        acc <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahfp_sub_ci.sv
module tb_ahfp_sub_ci;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic [31:0] core_dataa;
    logic [31:0] core_datab;
    logic [31:0] core_result;

    logic        core_ovr_en;
    logic [31:0] core_ovr;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    ahfp_sub_ci #(.CORE_LAT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .start       (start),
        .n           (n),
        .dataa       (dataa),
        .datab       (datab),
        .result      (result),
        .done        (done),
        .core_dataa  (core_dataa),
        .core_datab  (core_datab),
        .core_result (core_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-precision helpers for the core model
    function automatic real f2r(input logic [31:0] v);
        real m;
        int  e;
        if (v[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(v[22:0]) / 8388608.0;
        e = int'(v[30:23]) - 127;
        for (int i = 0; i < 300 && e > 0; i++) begin m = m * 2.0; e--; end
        for (int i = 0; i < 300 && e < 0; i++) begin m = m / 2.0; e++; end
        return v[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic s;
        int   e;
        real  m;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 127;
        for (int i = 0; i < 300 && m >= 2.0; i++) begin m = m / 2.0; e++; end
        for (int i = 0; i < 300 && m < 1.0; i++) begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    always_comb begin
        if (core_ovr_en) core_result = core_ovr;
        else             core_result = r2f(f2r(core_dataa) - f2r(core_datab));
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Presents a request in cycle 0; returns at the sampling point of cycle 1.
    task automatic issue(input logic [1:0] nn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        n     = nn;
        dataa = a;
        datab = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the cycle-1 sample point; lat = cycle in which done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int first;
        logic [31:0] res;
        logic [31:0] ovr_in [3];
        logic [31:0] ovr_exp [3];

        total = 0;
        bad   = 0;
        core_ovr_en = 1'b0;
        core_ovr    = 32'd0;

        vt[0]  = '{2'd0, 32'h40400000, 32'h3F800000, 32'h40000000, 3}; // 3-1
        vt[1]  = '{2'd0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1}; // inf-inf
        vt[2]  = '{2'd1, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1}; // NaN
        vt[3]  = '{2'd0, 32'h41200000, 32'h41200000, 32'h00000000, 1}; // X==Y
        vt[4]  = '{2'd0, 32'h00000001, 32'h3F800000, 32'hBF800000, 1}; // denorm X
        vt[5]  = '{2'd1, 32'h3F800000, 32'hFF800000, 32'hFF800000, 1}; // X=-inf
        vt[6]  = '{2'd0, 32'h3F800000, 32'hFF800000, 32'h7F800000, 1}; // Y=-inf
        vt[7]  = '{2'd0, 32'h40400000, 32'h80000000, 32'h40400000, 1}; // Y=-0
        vt[8]  = '{2'd1, 32'h3F800000, 32'h40400000, 32'h40000000, 3}; // B-A
        vt[9]  = '{2'd0, 32'hFF800000, 32'h7F800000, 32'hFF800000, 1}; // -inf-inf
        vt[10] = '{2'd3, 32'h41200000, 32'h00000000, 32'h41200000, 1}; // acc<=10
        vt[11] = '{2'd2, 32'h3F800000, 32'h00000000, 32'h41100000, 3}; // acc-1
        vt[12] = '{2'd2, 32'h3F800000, 32'h00000000, 32'h41000000, 3}; // acc-1
        vt[13] = '{2'd2, 32'h00000000, 32'h00000000, 32'h41000000, 1}; // reads acc

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        n      = 2'd0;
        dataa  = 32'd0;
        datab  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check32("reset done",   {31'd0, done}, 32'd0);
        check32("reset result", result,        32'd0);
        check32("reset core_a", core_dataa,    32'd0);
        check32("reset core_b", core_datab,    32'd0);

        // Core operand timing for 3.0 - 1.0
        issue(2'd0, 32'h40400000, 32'h3F800000);
        check32("c1 core_a", core_dataa, 32'h40400000);
        check32("c1 core_b", core_datab, 32'h3F800000);
        check32("c1 done",   {31'd0, done}, 32'd0);
        @(negedge clk);
        check32("c2 core_a", core_dataa, 32'h40400000);
        check32("c2 done",   {31'd0, done}, 32'd0);
        @(negedge clk);
        check32("c3 done",   {31'd0, done}, 32'd1);
        check32("c3 result", result, 32'h40000000);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(vt[i].n, vt[i].a, vt[i].b);
            wait_done(lat);
            check32($sformatf("v%0d result", i), result, vt[i].res);
            check32($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
            @(negedge clk);
            check32($sformatf("v%0d pulse", i), {31'd0, done}, 32'd0);
            check32($sformatf("v%0d hold", i), result, vt[i].res);
        end

        // Stall during EXEC, plus a start pulse while busy
        issue(2'd0, 32'h40400000, 32'h3F800000);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        check32("stall done", {31'd0, done}, 32'd0);
        check32("stall core_a", core_dataa, 32'h40400000);
        clk_en = 1'b1;
        n      = 2'd3;
        dataa  = 32'h3F800000;
        start  = 1'b1;
        ndone  = 0;
        first  = 0;
        res    = 32'd0;
        for (int c = 4; c <= 12; c++) begin
            if (c > 4) @(negedge clk);
            if (c == 5) start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = c;
                    res   = result;
                end
            end
        end
        check32("stall latency", 32'(first), 32'd6);
        check32("stall ndone",   32'(ndone), 32'd1);
        check32("stall result",  res, 32'h40000000);

        // done held by clk_en=0; start during DONE ignored
        issue(2'd0, 32'h41200000, 32'h41200000);
        check32("hold done c1", {31'd0, done}, 32'd1);
        clk_en = 1'b0;
        @(negedge clk);
        check32("hold done stalled", {31'd0, done}, 32'd1);
        clk_en = 1'b1;
        n      = 2'd3;
        dataa  = 32'h12345678;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check32("done-start c2", {31'd0, done}, 32'd0);
        @(negedge clk);
        check32("done-start c3", {31'd0, done}, 32'd0);
        check32("done-start result", result, 32'h00000000);

        // Reset mid-EXEC with clk_en low
        issue(2'd3, 32'h41200000, 32'h00000000);
        wait_done(lat);
        check32("preload result", result, 32'h41200000);
        @(negedge clk);
        issue(2'd0, 32'h40400000, 32'h3F800000);
        reset  = 1'b1;
        clk_en = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        clk_en = 1'b1;
        ndone  = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check32("rst ndone",  32'(ndone), 32'd0);
        check32("rst result", result,     32'd0);
        check32("rst core_a", core_dataa, 32'd0);
        check32("rst core_b", core_datab, 32'd0);
        issue(2'd2, 32'hBF800000, 32'h00000000);   // 0 - (-1) only if acc cleared
        wait_done(lat);
        check32("rst acc", result, 32'h3F800000);
        check32("rst acc lat", 32'(lat), 32'd1);
        @(negedge clk);
        issue(2'd0, 32'h40400000, 32'h3F800000);
        wait_done(lat);
        check32("post-rst result", result, 32'h40000000);
        check32("post-rst lat", 32'(lat), 32'd3);
        @(negedge clk);

        // Core result canonicalisation
        ovr_in[0] = 32'h7F80ABCD; ovr_exp[0] = 32'h7F800000;
        ovr_in[1] = 32'h00012345; ovr_exp[1] = 32'h00000000;
        ovr_in[2] = 32'h80012345; ovr_exp[2] = 32'h00000000;
        core_ovr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core_ovr = ovr_in[i];
            issue(2'd0, 32'h40400000, 32'h3F800000);
            wait_done(lat);
            check32($sformatf("canon%0d result", i), result, ovr_exp[i]);
            check32($sformatf("canon%0d lat", i), 32'(lat), 32'd3);
            @(negedge clk);
        end
        core_ovr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahfp_sub_ci.md
# ahfp_sub_ci

Multi-cycle custom-instruction front-end for the floating-point subtractor datapath. It registers and screens the processor's operands, handles IEEE-754 single-precision special cases itself, and presents clean operands to the combinational subtractor core. It waits a fixed settle time, then captures, canonicalises and returns the core's result with a one-cycle `done` pulse. It also keeps a running accumulator so the processor can issue repeated subtract-from-accumulator operations without reloading.

## Interface

Parameters:
- `CORE_LAT`, default 2: cycles core operands are held before `core_result` is sampled; legal range 1..15.

Ports:
- `clk`  in  1: sole clock; every register updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `clk_en`  in  1: when 0, all state, counters and outputs hold.
- `start`  in  1: operation request, sampled only in IDLE with `clk_en`=1.
- `n`  in  2: operation select, captured with `start`.
- `dataa`  in  32: operand A, IEEE-754 single.
- `datab`  in  32: operand B, IEEE-754 single.
- `result`  out  32: registered result.
- `done`  out  1: one-cycle pulse; `result` is valid in that cycle.
- `core_dataa`  out  32: registered minuend to the core.
- `core_datab`  out  32: registered subtrahend to the core.
- `core_result`  in  32: core output. Contract: `core_dataa − core_datab`, combinational, stable within `CORE_LAT` cycles.

## Operation

- `n` encoding:
  - 0: A−B.
  - 1: B−A.
  - 2: acc−A, then acc ← result.
  - 3: acc ← A, result = A, no core use.
- Effective operands (X, Y) are formed from `n`. Denormal inputs (exp=0) are flushed to signed zero before any check.
- Special-case screen, in priority order:
  - Either operand NaN (exp=FF, mant≠0): result 7FC00000.
  - Inf−inf with the same sign: result 7FC00000.
  - X inf: result X.
  - Y inf: result Y with its sign flipped.
  - X==Y bitwise: result 00000000.
  - Y zero: result X.
  - X zero: result Y with its sign flipped.
  - Otherwise: core path.
- Core-result canonicalisation:
  - exp=FF: force mant=0, keep sign.
  - exp=00: force 00000000.
- FSM, three states:
  - IDLE: on `start`, either load `core_dataa/b` ← X,Y, counter ← `CORE_LAT`−1, and go to EXEC; or, for a special case or n=3, load `result` and go to DONE.
  - EXEC: decrement the counter. At 0, capture the canonicalised `core_result` into `result` and go to DONE.
  - DONE: `done`=1. Update acc if n∈{2,3}. Return to IDLE.
- Accumulator is 32 bits. It changes only in DONE for n=2/3 and on reset.

## Timing

- Cycle 0 = `start` accepted. Core path: `done` in cycle `CORE_LAT`+1. Bypass path: `done` in cycle 1.
- `core_dataa/b` are stable from cycle 1 through cycle `CORE_LAT` inclusive. They keep their last value afterwards.
- `result` holds its value until the next DONE.
- `start` in EXEC or DONE is ignored and not queued.
- `start` in the same cycle as DONE is also ignored. Back-to-back operations issue in the cycle after `done` at the earliest.
- `clk_en`=0 freezes state, counter, acc and `done`. A pending pulse stays high and completes once `clk_en` returns. Latency stretches by exactly the number of stalled cycles.
- Reset (any state, regardless of `clk_en`):
  - state IDLE;
  - `done`=0;
  - `result`, acc, `core_dataa`, `core_datab` = 0;
  - counter = 0.
  - An in-flight operation is abandoned with no `done`.
- n=2 issued immediately after an n=3 load sees the updated acc.

## Structure

- Shared package `ahfp_pkg`:
  - `QNAN` = 32'h7FC00000;
  - `EXP_MAX` = 8'hFF;
  - operation encodings `OP_AB`, `OP_BA`, `OP_ACC`, `OP_LOAD`;
  - FSM state enum;
  - `is_nan` / `is_inf` / `is_zero` classification functions, reused by the other ahfp stages.
- One sub-module, `ahfp_classify`: combinational special-case screen taking X, Y and returning `bypass` and `bypass_val`.
- FSM, counter, accumulator and output registers live in the top.

## Test plan

Bench models the core as a behavioural subtract with `CORE_LAT`=2.

- n=0, A=40400000 (3.0), B=3F800000 (1.0) → `result`=40000000, `done` in cycle 3, `core_dataa`=40400000 during cycles 1–2.
- n=0, A=7F800000, B=7F800000 → 7FC00000, `done` in cycle 1. n=1, A=7FC00001 → 7FC00000. n=0, A=B=41200000 → 00000000, `done` in cycle 1.
- n=3, A=41200000 (10.0), then n=2, A=3F800000 twice → `result` 41200000, 41100000, 41000000; acc ends at 41000000.
- `clk_en` low for 3 cycles in EXEC (3.0−1.0) → `done` in cycle 6, `result` 40000000. `start` pulsed during EXEC → ignored, exactly one `done`.
- `reset` asserted in cycle 1 of EXEC → no `done`; `result`, acc and core outputs = 0. Next n=0 op (3.0−1.0) completes normally in cycle 3.
- Core returns 7F80ABCD → `result` 7F800000. Core returns 00012345 → `result` 00000000.
